// File: rtl/watch_mode_ctrl_if.sv
// Mode, event and display bus between the watch mode controller (master)
// and the clock/stopwatch/alarm sub-blocks (slave).
interface watch_mode_ctrl_if;
    logic [23:0] disp_clk;
    logic [23:0] disp_sw;
    logic [23:0] disp_alm;
    logic [1:0]  mode;
    logic        mode_chg;
    logic [2:0]  a_pulse;
    logic [2:0]  a_long;
    logic [2:0]  b_pulse;
    logic [23:0] digits;

    modport master (
        input  disp_clk, disp_sw, disp_alm,
        output mode, mode_chg, a_pulse, a_long, b_pulse, digits
    );

    modport slave (
        output disp_clk, disp_sw, disp_alm,
        input  mode, mode_chg, a_pulse, a_long, b_pulse, digits
    );
endinterface

// File: rtl/watch_mode_ctrl.sv
// Watch mode controller: debounces KEY[2:0], steps CLOCK->STOPWATCH->ALARM, routes button
// events to the owning mode and muxes its digits. Define AUTO_RETURN_EN for ALARM idle return.
module watch_mode_ctrl #(
    parameter int unsigned DEBOUNCE_CYC = 32'd500000,
    parameter int unsigned LONG_CYC     = 32'd50000000,
    parameter int unsigned IDLE_CYC     = 32'd500000000
) (
    input  logic              CLOCK_50,
    input  logic              RESET_N,
    input  logic [2:0]        KEY,
    watch_mode_ctrl_if.master bus
);
    localparam int DB_W   = $clog2(DEBOUNCE_CYC + 32'd1);
    localparam int LONG_W = $clog2(LONG_CYC + 32'd1);
    localparam logic [DB_W-1:0]   DB_LAST   = DB_W'(DEBOUNCE_CYC - 32'd1);
    localparam logic [LONG_W-1:0] LONG_LAST = LONG_W'(LONG_CYC - 32'd1);
    localparam logic [LONG_W-1:0] LONG_MAX  = LONG_W'(LONG_CYC);

    if (DEBOUNCE_CYC < 32'd2 || LONG_CYC < 32'd2 || IDLE_CYC < 32'd2) begin : g_param_check
        $error("watch_mode_ctrl: cycle parameters must be at least 2");
    end

    typedef enum logic [1:0] {
        MODE_CLOCK = 2'd0,
        MODE_SW    = 2'd1,
        MODE_ALARM = 2'd2,
        MODE_BAD   = 2'd3
    } mode_e;

    function automatic logic [2:0] mode_onehot(input logic [1:0] m);
        case (m)
            2'd0:    mode_onehot = 3'b001;
            2'd1:    mode_onehot = 3'b010;
            2'd2:    mode_onehot = 3'b100;
            default: mode_onehot = 3'b000;
        endcase
    endfunction

    // Button levels are kept active-high (1 = pressed) from the first flop onwards.
    logic [2:0]      sync1_r, sync2_r, deb_r, armed_r;
    logic [1:0]      vld_r;
    logic [DB_W-1:0] db_cnt_r [3];
    logic [2:0]      tog_s, press_s, rel_s;
    mode_e           state_r, state_s;
    logic            chg_s, idle_hit_s, short_s, long_s;
    logic [2:0]      own_s;
    logic            a_act_r;
    logic [LONG_W-1:0] hold_r;
    logic            mode_chg_r;
    logic [2:0]      a_pulse_r, a_long_r, b_pulse_r;
    logic [23:0]     digits_r;

    // Debounced edges; a key held through reset stays unarmed until seen released.
    always_comb begin
        tog_s   = 3'b000;
        press_s = 3'b000;
        rel_s   = 3'b000;
        for (int i = 0; i < 3; i++) begin
            tog_s[i]   = (sync2_r[i] != deb_r[i]) && (db_cnt_r[i] == DB_LAST);
            press_s[i] = tog_s[i] && !deb_r[i] && armed_r[i];
            rel_s[i]   = tog_s[i] && deb_r[i];
        end
    end

    // Synchroniser, debounce counters and post-reset arming.
    always_ff @(posedge CLOCK_50 or negedge RESET_N) begin
        if (!RESET_N) begin
            sync1_r <= 3'b000;
            sync2_r <= 3'b000;
            deb_r   <= 3'b000;
            armed_r <= 3'b000;
            vld_r   <= 2'b00;
            for (int i = 0; i < 3; i++) db_cnt_r[i] <= {DB_W{1'b0}};
        end else begin
            sync1_r <= ~KEY;
            sync2_r <= sync1_r;
            vld_r   <= {vld_r[0], 1'b1};
            armed_r <= armed_r | ({3{vld_r[1]}} & ~sync2_r);
            deb_r   <= deb_r ^ tog_s;
            for (int i = 0; i < 3; i++) begin
                if ((sync2_r[i] == deb_r[i]) || tog_s[i]) db_cnt_r[i] <= {DB_W{1'b0}};
                else                                      db_cnt_r[i] <= db_cnt_r[i] + DB_W'(1'b1);
            end
        end
    end

`ifdef AUTO_RETURN_EN
    localparam int IDLE_W = $clog2(IDLE_CYC + 32'd1);
    localparam logic [IDLE_W-1:0] IDLE_LAST = IDLE_W'(IDLE_CYC - 32'd1);
    logic [IDLE_W-1:0] idle_r;

    assign idle_hit_s = (state_r == MODE_ALARM) && !(|tog_s) && (idle_r == IDLE_LAST);

    // ALARM inactivity counter; any debounced edge restarts it.
    always_ff @(posedge CLOCK_50 or negedge RESET_N) begin
        if (!RESET_N)                                                  idle_r <= {IDLE_W{1'b0}};
        else if ((state_r != MODE_ALARM) || (|tog_s) || idle_hit_s)   idle_r <= {IDLE_W{1'b0}};
        else                                                           idle_r <= idle_r + IDLE_W'(1'b1);
    end
`else
    assign idle_hit_s = 1'b0;
`endif

    // Mode state register.
    always_ff @(posedge CLOCK_50 or negedge RESET_N) begin
        if (!RESET_N) state_r <= MODE_CLOCK;
        else          state_r <= state_s;
    end

    // Next mode; the illegal encoding recovers to CLOCK.
    always_comb begin
        state_s = state_r;
        chg_s   = 1'b0;
        case (state_r)
            MODE_CLOCK: if (press_s[2]) state_s = MODE_SW;    else state_s = MODE_CLOCK;
            MODE_SW:    if (press_s[2]) state_s = MODE_ALARM; else state_s = MODE_SW;
            MODE_ALARM: if (press_s[2] || idle_hit_s) state_s = MODE_CLOCK; else state_s = MODE_ALARM;
            default:    state_s = MODE_CLOCK;
        endcase
        chg_s = (state_s != state_r);
    end

    // Event qualification for the current owner.
    always_comb begin
        own_s   = mode_onehot(state_r);
        short_s = a_act_r && rel_s[0] && (hold_r < LONG_MAX);
        long_s  = a_act_r && !rel_s[0] && (hold_r == LONG_LAST);
    end

    // Button A hold tracker; a mode change cancels the hold in progress.
    always_ff @(posedge CLOCK_50 or negedge RESET_N) begin
        if (!RESET_N) begin
            a_act_r <= 1'b0;
            hold_r  <= {LONG_W{1'b0}};
        end else if (chg_s || rel_s[0]) begin
            a_act_r <= 1'b0;
            hold_r  <= {LONG_W{1'b0}};
        end else if (press_s[0]) begin
            a_act_r <= 1'b1;
            hold_r  <= {LONG_W{1'b0}};
        end else if (a_act_r && (hold_r != LONG_MAX)) begin
            a_act_r <= 1'b1;
            hold_r  <= hold_r + LONG_W'(1'b1);
        end else begin
            a_act_r <= a_act_r;
            hold_r  <= hold_r;
        end
    end

    // Registered outputs: events lose to a simultaneous mode change.
    always_ff @(posedge CLOCK_50 or negedge RESET_N) begin
        if (!RESET_N) begin
            mode_chg_r <= 1'b0;
            a_pulse_r  <= 3'b000;
            a_long_r   <= 3'b000;
            b_pulse_r  <= 3'b000;
            digits_r   <= 24'h000000;
        end else begin
            mode_chg_r <= chg_s;
            a_pulse_r  <= (short_s && !chg_s)    ? own_s : 3'b000;
            a_long_r   <= (long_s && !chg_s)     ? own_s : 3'b000;
            b_pulse_r  <= (press_s[1] && !chg_s) ? own_s : 3'b000;
            case (state_r)
                MODE_CLOCK: digits_r <= bus.disp_clk;
                MODE_SW:    digits_r <= bus.disp_sw;
                MODE_ALARM: digits_r <= bus.disp_alm;
                default:    digits_r <= 24'h000000;
            endcase
        end
    end

    assign bus.mode     = state_r;
    assign bus.mode_chg = mode_chg_r;
    assign bus.a_pulse  = a_pulse_r;
    assign bus.a_long   = a_long_r;
    assign bus.b_pulse  = b_pulse_r;
    assign bus.digits   = digits_r;
endmodule

// File: tb/tb_watch_mode_ctrl.sv
// Bench for watch_mode_ctrl: directed scenarios plus random button traffic, all checked
// every cycle against a cycle-counting behavioural model of the controller.
module tb_watch_mode_ctrl;
    localparam int D = 4;
    localparam int L = 20;
    localparam int I = 50;
    localparam logic [23:0] C_CLK = 24'h235959;
    localparam logic [23:0] C_SW  = 24'h001234;
    localparam logic [23:0] C_ALM = 24'h070000;

    logic       CLOCK_50 = 1'b0;
    logic       RESET_N;
    logic [2:0] KEY;
    watch_mode_ctrl_if bus ();

    watch_mode_ctrl #(.DEBOUNCE_CYC(D), .LONG_CYC(L), .IDLE_CYC(I)) dut (
        .CLOCK_50(CLOCK_50), .RESET_N(RESET_N), .KEY(KEY), .bus(bus)
    );

    always #5 CLOCK_50 = ~CLOCK_50;

    int tests = 0;
    int fails = 0;
    int n_ap = 0, n_al = 0, n_bp = 0, n_chg = 0;
    logic [2:0] last_ap = 3'b000, last_al = 3'b000;

    task automatic check(input string name, input logic [23:0] act, input logic [23:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %h, expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // Model state: per-key sample history and consecutive-disagreement run, mode as an integer,
    // and the cycle number at which the current A hold began.
    logic [3:0] hist_q[$];
    bit   m_deb[3];
    int   m_run[3];
    bit   m_armed[3];
    int   m_mode, m_cyc, m_start, m_idle;
    bit   m_act;
    logic [1:0]  e_mode = 2'd0;
    logic        e_chg = 1'b0;
    logic [2:0]  e_ap = 3'b000, e_al = 3'b000, e_bp = 3'b000;
    logic [23:0] e_dig = 24'h0;
    logic [3:0]  s_m;
    logic [2:0]  pe_m, rel_m;
    bit          any_m;
    int          old_m, new_m;

    always @(posedge CLOCK_50 or negedge RESET_N) begin
        if (!RESET_N) begin
            hist_q.delete();
            hist_q.push_back(4'b0000);
            hist_q.push_back(4'b0000);
            for (int k = 0; k < 3; k++) begin m_deb[k] = 0; m_run[k] = 0; m_armed[k] = 0; end
            m_mode = 0; m_cyc = 0; m_start = 0; m_idle = 0; m_act = 0;
            e_mode = 2'd0; e_chg = 1'b0; e_ap = 3'b000; e_al = 3'b000; e_bp = 3'b000; e_dig = 24'h0;
        end else begin
            m_cyc++;
            hist_q.push_back({1'b1, ~KEY});
            s_m = hist_q.pop_front();      // bit3 marks a real (post-reset) sample
            old_m = m_mode;
            e_dig = (old_m == 0) ? bus.disp_clk : (old_m == 1) ? bus.disp_sw : bus.disp_alm;
            pe_m = 3'b000; rel_m = 3'b000; any_m = 0;
            for (int k = 0; k < 3; k++) begin
                if (s_m[k] != m_deb[k]) begin
                    m_run[k]++;
                    if (m_run[k] == D) begin
                        m_deb[k] = s_m[k]; m_run[k] = 0; any_m = 1;
                        if (m_deb[k]) pe_m[k] = m_armed[k];
                        else          rel_m[k] = 1'b1;
                    end
                end else m_run[k] = 0;
                if (s_m[3] && !s_m[k]) m_armed[k] = 1;
            end
            new_m = pe_m[2] ? (old_m + 1) % 3 : old_m;
`ifdef AUTO_RETURN_EN
            if (old_m == 2 && !any_m) begin
                m_idle++;
                if (m_idle == I) new_m = 0;
            end else m_idle = 0;
            if (new_m != old_m) m_idle = 0;
`endif
            e_ap = 3'b000; e_al = 3'b000; e_bp = 3'b000;
            if (new_m != old_m) m_act = 0;
            else begin
                if (pe_m[1]) e_bp[old_m] = 1'b1;
                if (rel_m[0] && m_act) begin
                    if (m_cyc - m_start <= L) e_ap[old_m] = 1'b1;
                    m_act = 0;
                end else if (m_act && (m_cyc - m_start == L)) e_al[old_m] = 1'b1;
                if (pe_m[0]) begin m_act = 1; m_start = m_cyc; end
            end
            e_chg = (new_m != old_m);
            m_mode = new_m;
            e_mode = 2'(new_m);
        end
    end

    // Per-cycle comparison against the model, plus event tallies for directed checks.
    always @(negedge CLOCK_50) begin
        if (RESET_N === 1'b1) begin
            check("mode", bus.mode, e_mode);
            check("mode_chg", bus.mode_chg, e_chg);
            check("a_pulse", bus.a_pulse, e_ap);
            check("a_long", bus.a_long, e_al);
            check("b_pulse", bus.b_pulse, e_bp);
            check("digits", bus.digits, e_dig);
            if (bus.a_pulse != 3'b000) begin n_ap++; last_ap = bus.a_pulse; end
            if (bus.a_long != 3'b000)  begin n_al++; last_al = bus.a_long; end
            if (bus.b_pulse != 3'b000) n_bp++;
            if (bus.mode_chg)          n_chg++;
        end
    end

    task automatic press(input int k, input int hold);
        @(posedge CLOCK_50); #2 KEY[k] = 1'b0;
        repeat (hold) @(posedge CLOCK_50);
        #2 KEY[k] = 1'b1;
        repeat (12) @(posedge CLOCK_50);
    endtask

    task automatic mode_step(input logic [1:0] exp_mode, input logic [23:0] exp_dig);
        bit got;
        got = 0;
        @(posedge CLOCK_50); #2 KEY[2] = 1'b0;
        for (int t = 0; t < 40 && !got; t++) begin
            @(negedge CLOCK_50);
            if (bus.mode_chg) got = 1;
        end
        check("mode_chg_seen", 24'(got), 24'd1);
        check("mode_after_step", bus.mode, exp_mode);
        @(negedge CLOCK_50);
        check("digits_new_source", bus.digits, exp_dig);
        @(posedge CLOCK_50); #2 KEY[2] = 1'b1;
        repeat (12) @(posedge CLOCK_50);
    endtask

    initial begin
        #1000000;
        $display("FAIL timeout: simulation did not finish");
        $fatal(1, "timeout");
    end

    initial begin
        int c0, a0, l0, b0;
        int rem[3];
        RESET_N = 1'b0;
        KEY = 3'b111;
        bus.disp_clk = C_CLK; bus.disp_sw = C_SW; bus.disp_alm = C_ALM;
        repeat (3) @(posedge CLOCK_50);
        #2 RESET_N = 1'b1;
        repeat (100) @(posedge CLOCK_50);
        @(negedge CLOCK_50);
        check("reset_idle_mode", bus.mode, 24'd0);
        check("reset_idle_chg_count", 24'(n_chg), 24'd0);

        // 3-cycle glitch, then a clean 10-cycle press
        c0 = n_chg;
        @(posedge CLOCK_50); #2 KEY[2] = 1'b0;
        repeat (3) @(posedge CLOCK_50);
        #2 KEY[2] = 1'b1;
        repeat (10) @(posedge CLOCK_50);
        #2 KEY[2] = 1'b0;
        repeat (5) @(posedge CLOCK_50);
        @(negedge CLOCK_50);
        check("debounce_mode_before", bus.mode, 24'd0);
        @(posedge CLOCK_50); @(negedge CLOCK_50);
        check("debounce_mode_at_6", bus.mode, 24'd1);
        check("debounce_chg_at_6", bus.mode_chg, 24'd1);
        repeat (4) @(posedge CLOCK_50);
        #2 KEY[2] = 1'b1;
        repeat (12) @(posedge CLOCK_50);
        check("debounce_single_chg", 24'(n_chg - c0), 24'd1);

        mode_step(2'd2, C_ALM);
        mode_step(2'd0, C_CLK);
        mode_step(2'd1, C_SW);

        a0 = n_ap; l0 = n_al;
        press(0, 10);
        check("short_count", 24'(n_ap - a0), 24'd1);
        check("short_vector", last_ap, 24'h2);
        check("short_no_long", 24'(n_al - l0), 24'd0);
        a0 = n_ap; l0 = n_al;
        press(0, 30);
        check("long_count", 24'(n_al - l0), 24'd1);
        check("long_vector", last_al, 24'h2);
        check("long_no_short", 24'(n_ap - a0), 24'd0);

        press(2, 10);
        press(2, 10);
        b0 = n_bp;
        @(posedge CLOCK_50); #2 KEY = 3'b001;
        repeat (10) @(posedge CLOCK_50);
        #2 KEY = 3'b111;
        repeat (12) @(posedge CLOCK_50);
        check("simul_mode", bus.mode, 24'd1);
        check("simul_b_dropped", 24'(n_bp - b0), 24'd0);

        a0 = n_ap; l0 = n_al;
        @(posedge CLOCK_50); #2 KEY[0] = 1'b0;
        repeat (8) @(posedge CLOCK_50);
        #2 KEY[2] = 1'b0;
        repeat (10) @(posedge CLOCK_50);
        #2 KEY[2] = 1'b1;
        repeat (15) @(posedge CLOCK_50);
        #2 KEY[0] = 1'b1;
        repeat (12) @(posedge CLOCK_50);
        check("hold_cancel_no_short", 24'(n_ap - a0), 24'd0);
        check("hold_cancel_no_long", 24'(n_al - l0), 24'd0);
        check("hold_cancel_mode", bus.mode, 24'd2);

`ifdef AUTO_RETURN_EN
        repeat (28) @(posedge CLOCK_50);
        press(0, 5);
        repeat (30) @(posedge CLOCK_50);
        @(negedge CLOCK_50);
        check("idle_restarted_mode", bus.mode, 24'd2);
        repeat (30) @(posedge CLOCK_50);
        @(negedge CLOCK_50);
        check("idle_return_mode", bus.mode, 24'd0);
`else
        repeat (60) @(posedge CLOCK_50);
        @(negedge CLOCK_50);
        check("no_idle_return_mode", bus.mode, 24'd2);
`endif
        if (bus.mode != 2'd0) press(2, 10);

        for (int k = 0; k < 3; k++) rem[k] = int'($urandom_range(1, 30));
        for (int c = 0; c < 3000; c++) begin
            @(posedge CLOCK_50); #2;
            bus.disp_clk = 24'($urandom);
            bus.disp_sw  = 24'($urandom);
            bus.disp_alm = 24'($urandom);
            for (int k = 0; k < 3; k++) begin
                rem[k]--;
                if (rem[k] <= 0) begin
                    KEY[k] = ~KEY[k];
                    rem[k] = ($urandom_range(0, 4) == 0) ? int'($urandom_range(1, 4))
                                                        : int'($urandom_range(5, 45));
                end
            end
        end
        @(posedge CLOCK_50); #2 KEY = 3'b111;
        bus.disp_clk = C_CLK; bus.disp_sw = C_SW; bus.disp_alm = C_ALM;
        repeat (20) @(posedge CLOCK_50);

        // Reset asserted mid-cycle while KEY[2] and KEY[0] are held
        @(posedge CLOCK_50); #2 KEY = 3'b010;
        repeat (20) @(posedge CLOCK_50);
        #3 RESET_N = 1'b0;
        #1;
        check("async_reset_mode", bus.mode, 24'd0);
        check("async_reset_chg", bus.mode_chg, 24'd0);
        check("async_reset_a_pulse", bus.a_pulse, 24'd0);
        check("async_reset_a_long", bus.a_long, 24'd0);
        check("async_reset_b_pulse", bus.b_pulse, 24'd0);
        check("async_reset_digits", bus.digits, 24'd0);
        @(posedge CLOCK_50); #2 RESET_N = 1'b1;
        c0 = n_chg; a0 = n_ap; l0 = n_al;
        repeat (30) @(posedge CLOCK_50);
        #2 KEY = 3'b111;
        repeat (15) @(posedge CLOCK_50);
        @(negedge CLOCK_50);
        check("held_reset_mode", bus.mode, 24'd0);
        check("held_reset_no_chg", 24'(n_chg - c0), 24'd0);
        check("held_reset_no_a", 24'(n_ap - a0 + n_al - l0), 24'd0);
        press(2, 10);
        check("rearmed_mode", bus.mode, 24'd1);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
